// File: rtl/multi_alarm_clock.sv
// -----------------------------------------------------------------------------
// multi_alarm_clock
//   24-hour BCD time-of-day clock with NUM_ALARMS independent alarm slots.
//   Each slot has an enable, a snooze counter and a three-state FSM
//   (IDLE / RINGING / SNOOZED). A prescaler turns TICK_DIV clk cycles into
//   one second. Every output is driven straight from a register.
//
// Ports
//   clk, reset_n           rising-edge clock, asynchronous active-low reset
//   H_in1/H_in0/M_in1/M_in0  BCD hour/minute value for LD_time and LD_alarm
//   LD_time                load H:M into the clock, seconds cleared
//   LD_alarm, al_sel       load H:M into alarm slot al_sel
//   al_en                  per-slot enable mask (0 forces the slot IDLE)
//   STOP_al                silence every ringing or snoozed slot
//   SNOOZE                 move every ringing slot to snoozed
//   Alarm, alarm_id        any slot ringing / lowest ringing slot index
//   sec_tick               one-cycle pulse in the cycle after time advances
//   H_out*/M_out*/S_out*   current time in BCD
//   o_dbg_state            packed per-slot FSM state, slot i at [2*i +: 2]
// -----------------------------------------------------------------------------
module multi_alarm_clock #(
  parameter int NUM_ALARMS = 4,
  parameter int TICK_DIV   = 1,
  parameter int SNOOZE_MIN = 5,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              H_in1,
  input  logic [3:0]              H_in0,
  input  logic [2:0]              M_in1,
  input  logic [3:0]              M_in0,
  input  logic                    LD_time,
  input  logic                    LD_alarm,
  input  logic [AW-1:0]           al_sel,
  input  logic [NUM_ALARMS-1:0]   al_en,
  input  logic                    STOP_al,
  input  logic                    SNOOZE,
  output logic                    Alarm,
  output logic [AW-1:0]           alarm_id,
  output logic                    sec_tick,
  output logic [1:0]              H_out1,
  output logic [3:0]              H_out0,
  output logic [2:0]              M_out1,
  output logic [3:0]              M_out0,
  output logic [2:0]              S_out1,
  output logic [3:0]              S_out0,
  output logic [2*NUM_ALARMS-1:0] o_dbg_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
  localparam logic [1:0] ST_SNOOZED = 2'd2;

  // Time registers
  logic [PW-1:0] r_presc;
  logic [1:0]    r_h1;
  logic [3:0]    r_h0;
  logic [2:0]    r_m1;
  logic [3:0]    r_m0;
  logic [2:0]    r_s1;
  logic [3:0]    r_s0;
  logic          r_sec_tick;

  // Alarm registers; slot time packed as {h1, h0, m1, m0}
  logic [12:0]   r_al_time [NUM_ALARMS];
  logic [1:0]    r_state   [NUM_ALARMS];
  logic [3:0]    r_snz     [NUM_ALARMS];
  logic          r_alarm;
  logic [AW-1:0] r_alarm_id;

  // Combinational next values
  logic          w_in_ok;
  logic          w_ld_time;
  logic          w_ld_alarm;
  logic          w_tick;
  logic          w_s_wrap;
  logic          w_m_wrap;
  logic          w_min_evt;
  logic [1:0]    w_h1_n;
  logic [3:0]    w_h0_n;
  logic [2:0]    w_m1_n;
  logic [3:0]    w_m0_n;
  logic [2:0]    w_s1_n;
  logic [3:0]    w_s0_n;
  logic [12:0]   w_new_hm;
  logic [12:0]   w_in_hm;
  logic [1:0]    w_state_n [NUM_ALARMS];
  logic [3:0]    w_snz_n   [NUM_ALARMS];
  logic          w_any_ring;
  logic [AW-1:0] w_ring_id;

  // A load value is accepted only when it is a real 24-hour time.
  assign w_in_ok = ((H_in1 < 2'd2 && H_in0 <= 4'd9) || (H_in1 == 2'd2 && H_in0 <= 4'd3))
                   && (M_in1 <= 3'd5) && (M_in0 <= 4'd9);
  assign w_ld_time  = LD_time && w_in_ok;
  assign w_ld_alarm = LD_alarm && w_in_ok && (int'(al_sel) < NUM_ALARMS);
  assign w_in_hm    = {H_in1, H_in0, M_in1, M_in0};

  // A time load restarts the second, so it suppresses the tick of that cycle.
  assign w_tick = (r_presc == PW'(TICK_DIV - 1)) && !w_ld_time;

  assign w_s_wrap  = (r_s1 == 3'd5) && (r_s0 == 4'd9);
  assign w_m_wrap  = (r_m1 == 3'd5) && (r_m0 == 4'd9);
  assign w_min_evt = w_tick && w_s_wrap;
  assign w_new_hm  = {w_h1_n, w_h0_n, w_m1_n, w_m0_n};

  // Time one second ahead of the current registers, with BCD carries.
  always_comb begin
    w_s1_n = r_s1;
    w_s0_n = r_s0;
    w_m1_n = r_m1;
    w_m0_n = r_m0;
    w_h1_n = r_h1;
    w_h0_n = r_h0;
    if (r_s0 == 4'd9) begin
      w_s0_n = 4'd0;
      w_s1_n = w_s_wrap ? 3'd0 : r_s1 + 3'd1;
    end else begin
      w_s0_n = r_s0 + 4'd1;
    end
    if (w_s_wrap) begin
      if (r_m0 == 4'd9) begin
        w_m0_n = 4'd0;
        w_m1_n = w_m_wrap ? 3'd0 : r_m1 + 3'd1;
      end else begin
        w_m0_n = r_m0 + 4'd1;
      end
      if (w_m_wrap) begin
        if (r_h1 == 2'd2 && r_h0 == 4'd3) begin
          w_h1_n = 2'd0;
          w_h0_n = 4'd0;
        end else if (r_h0 == 4'd9) begin
          w_h0_n = 4'd0;
          w_h1_n = r_h1 + 2'd1;
        end else begin
          w_h0_n = r_h0 + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc    <= '0;
      r_h1       <= '0;
      r_h0       <= '0;
      r_m1       <= '0;
      r_m0       <= '0;
      r_s1       <= '0;
      r_s0       <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      if (w_ld_time || w_tick) r_presc <= '0;
      else                     r_presc <= r_presc + PW'(1);
      if (w_ld_time) begin
        r_h1 <= H_in1;
        r_h0 <= H_in0;
        r_m1 <= M_in1;
        r_m0 <= M_in0;
        r_s1 <= 3'd0;
        r_s0 <= 4'd0;
      end else if (w_tick) begin
        r_h1 <= w_h1_n;
        r_h0 <= w_h0_n;
        r_m1 <= w_m1_n;
        r_m0 <= w_m0_n;
        r_s1 <= w_s1_n;
        r_s0 <= w_s0_n;
      end
    end
  end

  // Per-slot FSM. Alarm/alarm_id are derived from the next-state vector so
  // they move on the same edge as the transition.
  always_comb begin
    w_any_ring = 1'b0;
    w_ring_id  = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_state_n[i] = r_state[i];
      w_snz_n[i]   = r_snz[i];
      if (!al_en[i]) begin
        w_state_n[i] = ST_IDLE;
      end else if (w_ld_alarm && (al_sel == AW'(i))) begin
        w_state_n[i] = ST_IDLE;
        w_snz_n[i]   = 4'd0;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_min_evt && (w_new_hm == r_al_time[i])) w_state_n[i] = ST_RINGING;
          end
          ST_RINGING: begin
            if (STOP_al) begin
              w_state_n[i] = ST_IDLE;
            end else if (SNOOZE) begin
              w_state_n[i] = ST_SNOOZED;
              w_snz_n[i]   = 4'(SNOOZE_MIN);
            end
          end
          ST_SNOOZED: begin
            if (STOP_al) begin
              w_state_n[i] = ST_IDLE;
            end else if (w_min_evt) begin
              if (r_snz[i] <= 4'd1) begin
                w_state_n[i] = ST_RINGING;
                w_snz_n[i]   = 4'd0;
              end else begin
                w_snz_n[i] = r_snz[i] - 4'd1;
              end
            end
          end
          default: w_state_n[i] = ST_IDLE;
        endcase
      end
    end
    // Scan downwards so the lowest ringing index wins.
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (w_state_n[i] == ST_RINGING) begin
        w_any_ring = 1'b1;
        w_ring_id  = AW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_al_time[i] <= '0;
        r_state[i]   <= ST_IDLE;
        r_snz[i]     <= '0;
      end
      r_alarm    <= 1'b0;
      r_alarm_id <= '0;
    end else begin
      if (w_ld_alarm) r_al_time[al_sel] <= w_in_hm;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_state[i] <= w_state_n[i];
        r_snz[i]   <= w_snz_n[i];
      end
      r_alarm    <= w_any_ring;
      r_alarm_id <= w_ring_id;
    end
  end

  always_comb begin
    o_dbg_state = '0;
    for (int i = 0; i < NUM_ALARMS; i++) o_dbg_state[2*i +: 2] = r_state[i];
  end

  assign Alarm    = r_alarm;
  assign alarm_id = r_alarm_id;
  assign sec_tick = r_sec_tick;
  assign H_out1   = r_h1;
  assign H_out0   = r_h0;
  assign M_out1   = r_m1;
  assign M_out0   = r_m0;
  assign S_out1   = r_s1;
  assign S_out0   = r_s0;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock. Instance A: 4 slots, one second per
// clk. Instance B: 5 slots, four clks per second. Times are compared as
// packed BCD, e.g. 24'h073000 is 07:30:00.
module tb_multi_alarm_clock;

  logic       clk;
  logic       reset_n_a;
  logic       reset_n_b;
  logic [1:0] h_in1;
  logic [3:0] h_in0;
  logic [2:0] m_in1;
  logic [3:0] m_in0;
  logic       ld_time;
  logic       ld_alarm;
  logic       stop_al;
  logic       snooze;
  logic [1:0] al_sel_a;
  logic [2:0] al_sel_b;
  logic [3:0] al_en_a;
  logic [4:0] al_en_b;

  logic       alarm_a, alarm_b, sec_tick_a, sec_tick_b;
  logic [1:0] alarm_id_a;
  logic [2:0] alarm_id_b;
  logic [1:0] h1_a, h1_b;
  logic [3:0] h0_a, h0_b, m0_a, m0_b, s0_a, s0_b;
  logic [2:0] m1_a, m1_b, s1_a, s1_b;
  logic [7:0] dbg_a;
  logic [9:0] dbg_b;

  wire [23:0] time_a = {2'b00, h1_a, h0_a, 1'b0, m1_a, m0_a, 1'b0, s1_a, s0_a};
  wire [23:0] time_b = {2'b00, h1_b, h0_b, 1'b0, m1_b, m0_b, 1'b0, s1_b, s0_b};

  int n_checks;
  int n_errors;

  multi_alarm_clock #(.NUM_ALARMS(4), .TICK_DIV(1), .SNOOZE_MIN(5)) dut_a (
    .clk(clk), .reset_n(reset_n_a),
    .H_in1(h_in1), .H_in0(h_in0), .M_in1(m_in1), .M_in0(m_in0),
    .LD_time(ld_time), .LD_alarm(ld_alarm), .al_sel(al_sel_a), .al_en(al_en_a),
    .STOP_al(stop_al), .SNOOZE(snooze),
    .Alarm(alarm_a), .alarm_id(alarm_id_a), .sec_tick(sec_tick_a),
    .H_out1(h1_a), .H_out0(h0_a), .M_out1(m1_a), .M_out0(m0_a),
    .S_out1(s1_a), .S_out0(s0_a), .o_dbg_state(dbg_a)
  );

  multi_alarm_clock #(.NUM_ALARMS(5), .TICK_DIV(4), .SNOOZE_MIN(5)) dut_b (
    .clk(clk), .reset_n(reset_n_b),
    .H_in1(h_in1), .H_in0(h_in0), .M_in1(m_in1), .M_in0(m_in0),
    .LD_time(ld_time), .LD_alarm(ld_alarm), .al_sel(al_sel_b), .al_en(al_en_b),
    .STOP_al(stop_al), .SNOOZE(snooze),
    .Alarm(alarm_b), .alarm_id(alarm_id_b), .sec_tick(sec_tick_b),
    .H_out1(h1_b), .H_out0(h0_b), .M_out1(m1_b), .M_out0(m0_b),
    .S_out1(s1_b), .S_out0(s0_b), .o_dbg_state(dbg_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n rising edges; returns 1 time unit after the last one
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_hm(input logic [1:0] a, input logic [3:0] b,
                        input logic [2:0] c, input logic [3:0] d);
    h_in1 = a; h_in0 = b; m_in1 = c; m_in0 = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n_a = 1'b1; reset_n_b = 1'b1;
    set_hm(2'd0, 4'd0, 3'd0, 4'd0);
    ld_time = 0; ld_alarm = 0; stop_al = 0; snooze = 0;
    al_sel_a = 0; al_sel_b = 0; al_en_a = 4'b0000; al_en_b = 5'b00010;

    // Reset
    #1;
    reset_n_a = 1'b0; reset_n_b = 1'b0;
    #2;
    chk("rst_time", time_a, 24'h000000);
    chk("rst_alarm", alarm_a, 1'b0);
    chk("rst_id", alarm_id_a, 2'd0);
    chk("rst_tick", sec_tick_a, 1'b0);
    @(posedge clk); #1;
    reset_n_a = 1'b1;

    // Alarm0 at 07:30, clock loaded to 07:29
    al_en_a = 4'b0001; al_sel_a = 2'd0;
    set_hm(2'd0, 4'd7, 3'd3, 4'd0); ld_alarm = 1;
    run(1);
    ld_alarm = 0;
    set_hm(2'd0, 4'd7, 3'd2, 4'd9); ld_time = 1;
    run(1);
    ld_time = 0;
    chk("ld_time", time_a, 24'h072900);
    chk("ld_no_tick", sec_tick_a, 1'b0);
    run(59);
    chk("pre_match_time", time_a, 24'h072959);
    chk("pre_match_alarm", alarm_a, 1'b0);
    run(1);
    chk("match_time", time_a, 24'h073000);
    chk("match_alarm", alarm_a, 1'b1);
    chk("match_id", alarm_id_a, 2'd0);
    chk("match_tick", sec_tick_a, 1'b1);
    run(5);
    chk("ring_holds", alarm_a, 1'b1);

    // Snooze for five minute events
    snooze = 1;
    run(1);
    snooze = 0;
    chk("snooze_time", time_a, 24'h073006);
    chk("snooze_alarm", alarm_a, 1'b0);
    chk("snooze_state", dbg_a[1:0], 2'd2);
    run(293);
    chk("snooze_pre_time", time_a, 24'h073459);
    chk("snooze_pre_alarm", alarm_a, 1'b0);
    run(1);
    chk("snooze_ring_time", time_a, 24'h073500);
    chk("snooze_ring_alarm", alarm_a, 1'b1);
    stop_al = 1;
    run(1);
    stop_al = 0;
    chk("stop_alarm", alarm_a, 1'b0);
    snooze = 1;
    run(1);
    snooze = 0;
    chk("idle_snooze_alarm", alarm_a, 1'b0);
    chk("idle_snooze_state", dbg_a[1:0], 2'd0);

    // Midnight wrap with alarm2 at 00:00
    al_en_a = 4'b0100; al_sel_a = 2'd2;
    set_hm(2'd0, 4'd0, 3'd0, 4'd0); ld_alarm = 1;
    run(1);
    ld_alarm = 0;
    set_hm(2'd2, 4'd3, 3'd5, 4'd9); ld_time = 1;
    run(1);
    ld_time = 0;
    run(58);
    chk("wrap_58", time_a, 24'h235958);
    run(1);
    chk("wrap_59", time_a, 24'h235959);
    chk("wrap_59_alarm", alarm_a, 1'b0);
    run(1);
    chk("wrap_00", time_a, 24'h000000);
    chk("wrap_alarm", alarm_a, 1'b1);
    chk("wrap_id", alarm_id_a, 2'd2);
    stop_al = 1;
    run(1);
    stop_al = 0;
    chk("wrap_stop", alarm_a, 1'b0);

    // Slots 1 and 3 both at 12:00
    al_en_a = 4'b1010;
    set_hm(2'd1, 4'd2, 3'd0, 4'd0); ld_alarm = 1; al_sel_a = 2'd1;
    run(1);
    al_sel_a = 2'd3;
    run(1);
    ld_alarm = 0;
    set_hm(2'd1, 4'd1, 3'd5, 4'd9); ld_time = 1;
    run(1);
    ld_time = 0;
    run(59);
    chk("dual_pre_alarm", alarm_a, 1'b0);
    run(1);
    chk("dual_time", time_a, 24'h120000);
    chk("dual_alarm", alarm_a, 1'b1);
    chk("dual_id_low", alarm_id_a, 2'd1);
    al_en_a = 4'b1000;
    run(1);
    chk("dual_id_high", alarm_id_a, 2'd3);
    chk("dual_alarm_kept", alarm_a, 1'b1);
    al_en_a = 4'b0000;
    run(1);
    chk("dis_alarm", alarm_a, 1'b0);
    chk("dis_id", alarm_id_a, 2'd0);

    // Invalid time loads are ignored
    set_hm(2'd2, 4'd4, 3'd0, 4'd0); ld_time = 1;
    run(1);
    chk("bad_hour", time_a, 24'h120003);
    set_hm(2'd0, 4'd1, 3'd0, 4'd10);
    run(1);
    chk("bad_min0", time_a, 24'h120004);
    set_hm(2'd0, 4'd1, 3'd6, 4'd0);
    run(1);
    ld_time = 0;
    chk("bad_min1", time_a, 24'h120005);

    // Simultaneous time + alarm load, then ring at the loaded alarm
    al_en_a = 4'b0001; al_sel_a = 2'd0;
    set_hm(2'd1, 4'd2, 3'd0, 4'd5); ld_time = 1; ld_alarm = 1;
    run(1);
    ld_alarm = 0;
    chk("both_ld_time", time_a, 24'h120500);
    set_hm(2'd1, 4'd2, 3'd0, 4'd4);
    run(1);
    ld_time = 0;
    run(60);
    chk("both_ld_ring_time", time_a, 24'h120500);
    chk("both_ld_alarm", alarm_a, 1'b1);
    chk("both_ld_id", alarm_id_a, 2'd0);

    // Instance B: prescaler of 4, out-of-range slot, async reset while ringing
    al_en_a = 4'b0000;
    reset_n_b = 1'b1;
    run(3);
    chk("b_tick_wait", sec_tick_b, 1'b0);
    chk("b_time_wait", time_b, 24'h000000);
    run(1);
    chk("b_tick_4th", sec_tick_b, 1'b1);
    chk("b_time_1s", time_b, 24'h000001);
    run(1);
    chk("b_tick_pulse", sec_tick_b, 1'b0);
    set_hm(2'd0, 4'd0, 3'd0, 4'd2); ld_alarm = 1; al_sel_b = 3'd1;
    run(1);
    set_hm(2'd0, 4'd0, 3'd0, 4'd1); al_sel_b = 3'd5;
    run(1);
    ld_alarm = 0;
    run(232);
    chk("b_time_59", time_b, 24'h000059);
    run(1);
    chk("b_time_0100", time_b, 24'h000100);
    chk("b_oob_ignored", alarm_b, 1'b0);
    run(240);
    chk("b_time_0200", time_b, 24'h000200);
    chk("b_ring", alarm_b, 1'b1);
    chk("b_ring_id", alarm_id_b, 3'd1);
    #2;
    reset_n_b = 1'b0;
    #1;
    chk("b_rst_alarm", alarm_b, 1'b0);
    chk("b_rst_time", time_b, 24'h000000);
    chk("b_rst_id", alarm_id_b, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
